// File: rtl/output_port_packetizer_pkg.sv
// Shared widths, packet layout and FSM encodings for the output-port packetizer.
// The optional OUT_PORT_STATS_EN build macro is consumed by the top module.
package output_port_packetizer_pkg;

    localparam int unsigned PACKET_BITS           = 97;
    localparam int unsigned NUM_LEAF_BITS         = 6;
    localparam int unsigned NUM_PORT_BITS         = 4;
    localparam int unsigned NUM_ADDR_BITS         = 7;
    localparam int unsigned PAYLOAD_BITS          = 64;
    localparam int unsigned DATA_USER_OUT         = 256;
    localparam int unsigned NUM_BRAM_ADDR_BITS    = 7;
    localparam int unsigned FREESPACE_UPDATE_SIZE = 64;

    localparam int unsigned BEATS       = DATA_USER_OUT / PAYLOAD_BITS;
    localparam int unsigned BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CTRL_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int unsigned CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam int unsigned CREDIT_MAX  = 2 ** NUM_BRAM_ADDR_BITS;
    localparam int unsigned PAD_BITS    = PACKET_BITS - 1 - CTRL_BITS - NUM_ADDR_BITS - PAYLOAD_BITS;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef struct packed {
        logic                     valid;
        logic [NUM_LEAF_BITS-1:0] dst_leaf;
        logic [NUM_PORT_BITS-1:0] dst_port;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [PAD_BITS-1:0]      pad;
        logic [PAYLOAD_BITS-1:0]  payload;
    } packet_t;

    function automatic packet_t make_packet(input logic [CTRL_BITS-1:0]     ctrl,
                                            input logic [NUM_ADDR_BITS-1:0] addr,
                                            input logic [PAYLOAD_BITS-1:0]  payload);
        packet_t p;
        p.valid    = 1'b1;
        p.dst_leaf = ctrl[CTRL_BITS-1:NUM_PORT_BITS];
        p.dst_port = ctrl[NUM_PORT_BITS-1:0];
        p.addr     = addr;
        p.pad      = '0;
        p.payload  = payload;
        return p;
    endfunction

endpackage

// File: rtl/output_port_packetizer_if.sv
// User-word handshake and BFT stream bundle; master is the packetizer side.
interface output_port_packetizer_if;
    import output_port_packetizer_pkg::*;

    logic [DATA_USER_OUT-1:0] din_user;
    logic                     vld_user2b_out;
    logic                     ack_b_out2user;
    logic [PACKET_BITS-1:0]   stream_out;
    logic                     stream_out_vld;
    logic                     stream_out_rdy;

    modport master (
        input  din_user, vld_user2b_out, stream_out_rdy,
        output ack_b_out2user, stream_out, stream_out_vld
    );

    modport slave (
        output din_user, vld_user2b_out, stream_out_rdy,
        input  ack_b_out2user, stream_out, stream_out_vld
    );
endinterface

// File: rtl/output_port_packetizer_out_credit_counter.sv
// Credits toward the remote input FIFO: decrement per sent packet, add per
// freespace update, clamp at full depth with a sticky overflow flag.
module out_credit_counter
    import output_port_packetizer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_i,
    input  logic                   inc_i,
    output logic [CREDIT_BITS-1:0] credit_o,
    output logic [CREDIT_BITS-1:0] credit_nxt_c,
    output logic                   overflow_o
);
    localparam int unsigned SUM_BITS = CREDIT_BITS + 1;

    logic [CREDIT_BITS-1:0] credit_q, credit_d;
    logic                   overflow_q, overflow_d;
    logic [SUM_BITS-1:0]    sum_c;

    // One extra bit of headroom so an update on a full counter is detectable
    always_comb begin
        credit_d   = credit_q;
        overflow_d = overflow_q;
        sum_c      = SUM_BITS'(credit_q);
        if (inc_i)
            sum_c = sum_c + SUM_BITS'(FREESPACE_UPDATE_SIZE);
        if (dec_i && (credit_q != '0))
            sum_c = sum_c - SUM_BITS'(1);
        if (sum_c > SUM_BITS'(CREDIT_MAX)) begin
            credit_d   = CREDIT_BITS'(CREDIT_MAX);
            overflow_d = 1'b1;
        end else begin
            credit_d = sum_c[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q   <= CREDIT_BITS'(CREDIT_MAX);
            overflow_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    assign credit_o     = credit_q;
    assign credit_nxt_c = credit_d;
    assign overflow_o   = overflow_q;
endmodule

// File: rtl/output_port_packetizer.sv
// Serializes one held user word into BEATS credit-gated packets on the BFT stream.
// Build macro OUT_PORT_STATS_EN enables the sent/stall statistics counters.
module output_port_packetizer
    import output_port_packetizer_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    output_port_packetizer_if.master port_if,
    input  logic [CTRL_BITS-1:0]     out_control_reg,
    input  logic                     freespace_update,
    output logic                     credit_overflow,
    output logic [PAYLOAD_BITS-1:0]  sent_cnt,
    output logic [PAYLOAD_BITS-1:0]  stall_cnt
);
    logic [0:0]               state_q, state_d;
    logic [DATA_USER_OUT-1:0] word_q, word_d;
    logic [CTRL_BITS-1:0]     ctrl_q, ctrl_d;
    logic [BEAT_BITS-1:0]     beat_q, beat_d;
    logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     ack_q, ack_d;
    logic                     vld_q, vld_d;
    packet_t                  pkt_q, pkt_d;
    logic                     handshake_c;
    logic [CREDIT_BITS-1:0]   credit_cnt;
    logic [CREDIT_BITS-1:0]   credit_nxt_c;

    assign handshake_c = vld_q & port_if.stream_out_rdy;

    out_credit_counter u_credit (
        .clk          (clk),
        .rst_n        (reset),
        .dec_i        (handshake_c),
        .inc_i        (freespace_update),
        .credit_o     (credit_cnt),
        .credit_nxt_c (credit_nxt_c),
        .overflow_o   (credit_overflow)
    );

    // vld is raised only when next-cycle credit is nonzero, so it never needs to drop
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ctrl_d  = ctrl_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        ack_d   = 1'b0;
        vld_d   = vld_q;
        case (state_q)
            ST_IDLE: begin
                vld_d = 1'b0;
                if (port_if.vld_user2b_out) begin
                    word_d  = port_if.din_user;
                    ctrl_d  = out_control_reg;
                    beat_d  = '0;
                    ack_d   = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake_c) begin
                    beat_d = beat_q + BEAT_BITS'(1);
                    addr_d = addr_q + NUM_ADDR_BITS'(1);
                    if (beat_q == BEAT_BITS'(BEATS - 1)) begin
                        state_d = ST_IDLE;
                        vld_d   = 1'b0;
                    end else begin
                        vld_d = (credit_nxt_c != '0);
                    end
                end else if (!vld_q) begin
                    vld_d = (credit_nxt_c != '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pkt_d = vld_d ? make_packet(ctrl_d, addr_d, word_d[PAYLOAD_BITS*beat_d +: PAYLOAD_BITS])
                      : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            ctrl_q  <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ctrl_q  <= ctrl_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
            pkt_q   <= pkt_d;
        end
    end

    assign port_if.ack_b_out2user = ack_q;
    assign port_if.stream_out_vld = vld_q;
    assign port_if.stream_out     = pkt_q;

`ifdef OUT_PORT_STATS_EN
    logic [PAYLOAD_BITS-1:0] sent_q, stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            if (handshake_c)
                sent_q <= sent_q + PAYLOAD_BITS'(1);
            if ((state_q == ST_SEND) && (credit_cnt == '0))
                stall_q <= stall_q + PAYLOAD_BITS'(1);
        end
    end

    assign sent_cnt  = sent_q;
    assign stall_cnt = stall_q;
`else
    logic unused_credit;
    assign unused_credit = ^credit_cnt;
    assign sent_cnt      = '0;
    assign stall_cnt     = '0;
`endif
endmodule

// File: tb/tb_output_port_packetizer.sv
// Directed bench for output_port_packetizer with immediate-assertion checks.
module tb_output_port_packetizer;
    import output_port_packetizer_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [CTRL_BITS-1:0]    out_ctrl;
    logic                    fsu;
    logic                    ovf;
    logic [PAYLOAD_BITS-1:0] sent_cnt;
    logic [PAYLOAD_BITS-1:0] stall_cnt;

    output_port_packetizer_if bus();

    output_port_packetizer dut (
        .clk              (clk),
        .reset            (reset),
        .port_if          (bus),
        .out_control_reg  (out_ctrl),
        .freespace_update (fsu),
        .credit_overflow  (ovf),
        .sent_cnt         (sent_cnt),
        .stall_cnt        (stall_cnt)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [6:0] exp_addr = '0;
    logic [7:0] cr_snap  = '0;
    int         vc;
    int         stalls;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_pkt(input logic [9:0] c, input logic [6:0] a,
                                             input logic [63:0] p);
        return {31'd0, 1'b1, c, a, 15'd0, p};
    endfunction

    task automatic do_reset;
        bus.vld_user2b_out = 1'b0;
        bus.din_user       = '0;
        bus.stream_out_rdy = 1'b1;
        fsu                = 1'b0;
        out_ctrl           = '0;
        reset              = 1'b1;
        #1 reset = 1'b0;
        tick;
        tick;
        reset    = 1'b1;
        tick;
        exp_addr = '0;
    endtask

    // Present a word, wait for the ack, then scramble inputs to prove they were captured
    task automatic send_word(input logic [255:0] w, input logic [9:0] c);
        int  b    = 0;
        bit  seen = 1'b0;
        bus.din_user       = w;
        out_ctrl           = c;
        bus.vld_user2b_out = 1'b1;
        while (!seen && b < 20) begin
            tick;
            b++;
            if (bus.ack_b_out2user) seen = 1'b1;
        end
        bus.vld_user2b_out = 1'b0;
        bus.din_user       = ~w;
        out_ctrl           = ~c;
        check("ack_seen", 128'(seen), 128'(1));
        check("vld_low_at_ack", 128'(bus.stream_out_vld), 128'(0));
    endtask

    // Accept the four beats of a word; optionally toggle rdy and pulse an update on beat upd_at
    task automatic recv(input logic [255:0] w, input logic [9:0] c, input bit toggle,
                        input int upd_at, output int vcyc);
        int k      = 0;
        int budget = 0;
        bit r      = 1'b1;
        bit pend   = 1'b0;
        vcyc = 0;
        while (k < 4 && budget < 300) begin
            tick;
            fsu = 1'b0;
            if (pend) begin
                cr_snap = dut.u_credit.credit_q;
                pend    = 1'b0;
            end
            if (budget == 0) check("ack_pulse", 128'(bus.ack_b_out2user), 128'(0));
            r = toggle ? ~r : 1'b1;
            bus.stream_out_rdy = r;
            if (bus.stream_out_vld) begin
                vcyc++;
                check("pkt", 128'(bus.stream_out), exp_pkt(c, exp_addr, w[k*64 +: 64]));
                if (r) begin
                    if (k == upd_at) begin
                        fsu  = 1'b1;
                        pend = 1'b1;
                    end
                    k++;
                    exp_addr++;
                end
            end
            budget++;
        end
        check("recv_beats", 128'(k), 128'(4));
        tick;
        fsu = 1'b0;
        if (pend) cr_snap = dut.u_credit.credit_q;
        bus.stream_out_rdy = 1'b1;
        check("vld_after_word", 128'(bus.stream_out_vld), 128'(0));
    endtask

    function automatic logic [255:0] mkword(input int n);
        return {64'(n * 4 + 4), 64'(n * 4 + 3), 64'(n * 4 + 2), 64'(n * 4 + 1)};
    endfunction

    initial begin
        logic [255:0] wa;
        logic [255:0] wb;
        wa = {64'd4, 64'd3, 64'd2, 64'd1};
        wb = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
              64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};

        // Reset state
        do_reset;
        check("rst_vld", 128'(bus.stream_out_vld), 128'(0));
        check("rst_stream", 128'(bus.stream_out), 128'(0));
        check("rst_ack", 128'(bus.ack_b_out2user), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        check("rst_credit", 128'(dut.u_credit.credit_q), 128'(128));
        check("rst_sent", 128'(sent_cnt), 128'(0));
        check("rst_stall", 128'(stall_cnt), 128'(0));

        // One word at full rate, leaf 5 port 3
        send_word(wa, {6'd5, 4'd3});
        recv(wa, {6'd5, 4'd3}, 1'b0, -1, vc);
        check("full_rate_cycles", 128'(vc), 128'(4));
        check("credit_124", 128'(dut.u_credit.credit_q), 128'(124));

        // rdy toggling: each packet held for one stalled cycle
        send_word(wb, {6'd42, 4'd9});
        recv(wb, {6'd42, 4'd9}, 1'b1, -1, vc);
        check("toggle_cycles", 128'(vc), 128'(8));
        check("credit_120", 128'(dut.u_credit.credit_q), 128'(120));

        // Reset after two beats discards the word
        send_word(wa, {6'd1, 4'd1});
        tick;
        check("mid_pkt0", 128'(bus.stream_out), exp_pkt({6'd1, 4'd1}, 7'd8, 64'd1));
        tick;
        check("mid_pkt1", 128'(bus.stream_out), exp_pkt({6'd1, 4'd1}, 7'd9, 64'd2));
        tick;
        reset = 1'b0;
        #1;
        check("midrst_vld", 128'(bus.stream_out_vld), 128'(0));
        check("midrst_stream", 128'(bus.stream_out), 128'(0));
        check("midrst_credit", 128'(dut.u_credit.credit_q), 128'(128));
        check("midrst_addr", 128'(dut.addr_q), 128'(0));
        tick;
        reset    = 1'b1;
        exp_addr = '0;
        tick;
        send_word(wb, {6'd2, 4'd7});
        recv(wb, {6'd2, 4'd7}, 1'b0, -1, vc);

        // Drain all 128 credits, then stall until a single update
        do_reset;
        for (int i = 0; i < 32; i++) begin
            send_word(mkword(i), {6'd3, 4'd2});
            recv(mkword(i), {6'd3, 4'd2}, 1'b0, -1, vc);
        end
        check("credit_zero", 128'(dut.u_credit.credit_q), 128'(0));
        check("addr_wrapped", 128'(exp_addr), 128'(0));
        send_word(mkword(32), {6'd3, 4'd2});
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (bus.stream_out_vld) stalls++;
        end
        check("stall_no_vld", 128'(stalls), 128'(0));
`ifdef OUT_PORT_STATS_EN
        check("stall_cnt_nz", 128'(stall_cnt != '0), 128'(1));
`else
        check("stall_cnt_off", 128'(stall_cnt), 128'(0));
`endif
        fsu = 1'b1;
        recv(mkword(32), {6'd3, 4'd2}, 1'b0, -1, vc);
        for (int i = 33; i < 48; i++) begin
            send_word(mkword(i), {6'd3, 4'd2});
            recv(mkword(i), {6'd3, 4'd2}, 1'b0, -1, vc);
        end
        check("credit_zero_again", 128'(dut.u_credit.credit_q), 128'(0));
        send_word(mkword(48), {6'd3, 4'd2});
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (bus.stream_out_vld) stalls++;
        end
        check("stall_after_64", 128'(stalls), 128'(0));
`ifdef OUT_PORT_STATS_EN
        check("sent_cnt_192", 128'(sent_cnt), 128'(192));
`else
        check("sent_cnt_off", 128'(sent_cnt), 128'(0));
`endif

        // Update coincident with a send at credit 10
        do_reset;
        for (int i = 0; i < 29; i++) begin
            send_word(mkword(i), {6'd7, 4'd4});
            recv(mkword(i), {6'd7, 4'd4}, 1'b0, -1, vc);
        end
        check("credit_12", 128'(dut.u_credit.credit_q), 128'(12));
        send_word(mkword(29), {6'd7, 4'd4});
        recv(mkword(29), {6'd7, 4'd4}, 1'b0, 2, vc);
        check("credit_73", 128'(cr_snap), 128'(73));
        check("credit_72", 128'(dut.u_credit.credit_q), 128'(72));
        check("no_ovf_coincident", 128'(ovf), 128'(0));

        // Updates at full credit clamp and latch overflow
        do_reset;
        fsu = 1'b1;
        tick;
        fsu = 1'b0;
        check("clamp1", 128'(dut.u_credit.credit_q), 128'(128));
        check("ovf1", 128'(ovf), 128'(1));
        fsu = 1'b1;
        tick;
        fsu = 1'b0;
        check("clamp2", 128'(dut.u_credit.credit_q), 128'(128));
        send_word(wa, {6'd5, 4'd3});
        recv(wa, {6'd5, 4'd3}, 1'b0, -1, vc);
        check("ovf_sticky", 128'(ovf), 128'(1));
        check("credit_after_clamp", 128'(dut.u_credit.credit_q), 128'(124));
        do_reset;
        check("ovf_cleared", 128'(ovf), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
